// File: rtl/tdm_demux2.sv
// ---------------------------------------------------------------------------
// tdm_demux2
//
// Two-channel serial time-division demultiplexer. Each serial bit arriving
// with din_valid is steered by sel to channel A (sel=0) or channel B (sel=1).
// Each channel shifts its bits in MSB-first, and every WIDTH bits it presents
// the completed word on its own valid/ready output port.
//
// Handshake: X_valid is high while X_data holds an unconsumed word, and
// X_data is stable for that whole time. The word is consumed on a rising edge
// where X_valid & X_ready are both high. A word that completes while the
// previous one is still held and not being consumed is dropped, and the
// sticky X_ovf flag is set.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   din, din_valid, sel   serial bit, qualifier, channel select (0=A, 1=B)
//   sync                  frame sync: discards partial words in both channels
//   a_data/a_valid/a_ready  channel A word port
//   b_data/b_valid/b_ready  channel B word port
//   a_ovf, b_ovf          sticky word-dropped flags
//   ovf_clr               synchronous clear of both sticky flags
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module tdm_demux2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sel,
  input  logic             sync,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic             a_ovf,
  output logic             b_ovf,
  input  logic             ovf_clr
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Per-channel word-port FSM. The state bit is the channel's valid output.
  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  // Index 0 is channel A, index 1 is channel B.
  state_e           state_q [2];
  state_e           state_d [2];
  logic [WIDTH-1:0] sh_q    [2];
  logic [WIDTH-1:0] sh_d    [2];
  logic [CW-1:0]    cnt_q   [2];
  logic [CW-1:0]    cnt_d   [2];
  logic [WIDTH-1:0] data_q  [2];
  logic [WIDTH-1:0] data_d  [2];
  logic [1:0]       ovf_q;
  logic [1:0]       ovf_d;

  logic [1:0]       ready_w;
  logic [1:0]       take_w;
  logic [1:0]       last_w;
  logic [1:0]       done_w;
  logic [WIDTH-1:0] word_w  [2];

  assign ready_w   = {b_ready, a_ready};
  assign take_w    = {din_valid & sel, din_valid & ~sel};
  assign last_w[0] = (cnt_q[0] == LAST);
  assign last_w[1] = (cnt_q[1] == LAST);
  // A sync edge restarts the frame, so a bit arriving with it never
  // completes a word.
  assign done_w    = take_w & last_w & {2{~sync}};
  assign word_w[0] = {sh_q[0][WIDTH-2:0], din};
  assign word_w[1] = {sh_q[1][WIDTH-2:0], din};

  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      state_d[ch] = state_q[ch];
      sh_d[ch]    = sh_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      data_d[ch]  = data_q[ch];
      ovf_d[ch]   = ovf_q[ch];

      // Deserialiser.
      if (sync) begin
        sh_d[ch]  = '0;
        cnt_d[ch] = '0;
        if (take_w[ch]) begin
          sh_d[ch]  = WIDTH'(din);
          cnt_d[ch] = CW'(1);
        end
      end else if (take_w[ch]) begin
        sh_d[ch]  = word_w[ch];
        cnt_d[ch] = last_w[ch] ? '0 : cnt_q[ch] + CW'(1);
      end

      // Word port.
      case (state_q[ch])
        COLLECT: begin
          if (done_w[ch]) begin
            data_d[ch]  = word_w[ch];
            state_d[ch] = HOLD;
          end
        end
        HOLD: begin
          if (done_w[ch]) begin
            if (ready_w[ch]) begin
              // Old word consumed and replaced on the same edge.
              data_d[ch] = word_w[ch];
            end else begin
              // Old word still held: drop the new one.
              ovf_d[ch] = 1'b1;
            end
          end else if (ready_w[ch]) begin
            state_d[ch] = COLLECT;
          end
        end
        default: state_d[ch] = COLLECT;
      endcase

      // Set has priority over clear.
      if (ovf_clr && !(done_w[ch] && state_q[ch] == HOLD && !ready_w[ch])) begin
        ovf_d[ch] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= COLLECT;
        sh_q[ch]    <= '0;
        cnt_q[ch]   <= '0;
        data_q[ch]  <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= state_d[ch];
        sh_q[ch]    <= sh_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
        data_q[ch]  <= data_d[ch];
      end
      ovf_q <= ovf_d;
    end
  end

  assign a_data  = data_q[0];
  assign b_data  = data_q[1];
  assign a_valid = (state_q[0] == HOLD);
  assign b_valid = (state_q[1] == HOLD);
  assign a_ovf   = ovf_q[0];
  assign b_ovf   = ovf_q[1];

endmodule

// File: tb/tb_tdm_demux2.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux2
//
// Bench for tdm_demux2 (WIDTH=8). A behavioural model tracks, per channel,
// how many bits of the current word have arrived and their numeric value,
// plus the held word, its valid flag and the sticky overflow flag. Every
// clock step compares all DUT outputs with the model. Directed sequences add
// hand-computed expectations for the multi-cycle corner cases.
// ---------------------------------------------------------------------------
module tb_tdm_demux2;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         din, din_valid, sel, sync;
  logic         a_ready, b_ready, ovf_clr;
  logic [W-1:0] a_data, b_data;
  logic         a_valid, b_valid, a_ovf, b_ovf;

  int checks = 0;
  int errors = 0;

  tdm_demux2 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .sel       (sel),
    .sync      (sync),
    .a_data    (a_data),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .b_data    (b_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .a_ovf     (a_ovf),
    .b_ovf     (b_ovf),
    .ovf_clr   (ovf_clr)
  );

  // Clock / reset block.
  always #5 clk = ~clk;

  // Reference model state (index 0 = A, 1 = B).
  int           m_cnt   [2];
  int           m_acc   [2];
  logic [W-1:0] m_data  [2];
  bit           m_valid [2];
  bit           m_ovf   [2];

  typedef struct {
    logic         din, dv, sel, sync, ar, br, clr;
    logic         exp_a_valid;
    logic [W-1:0] exp_a_data;
    logic         exp_b_valid;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_cnt[ch] = 0; m_acc[ch] = 0; m_data[ch] = '0;
      m_valid[ch] = 0; m_ovf[ch] = 0;
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    for (int ch = 0; ch < 2; ch++) begin
      bit take, rdy, done, drop;
      int word;
      take = din_valid && (sel == ch[0]);
      rdy  = (ch == 0) ? a_ready : b_ready;
      done = 0;
      word = 0;
      if (sync) begin
        m_cnt[ch] = take ? 1 : 0;
        m_acc[ch] = take ? int'(din) : 0;
      end else if (take) begin
        m_acc[ch] = (m_acc[ch] * 2 + int'(din)) % (1 << W);
        m_cnt[ch] = m_cnt[ch] + 1;
        if (m_cnt[ch] == W) begin
          done = 1; word = m_acc[ch];
          m_cnt[ch] = 0; m_acc[ch] = 0;
        end
      end
      drop = done && m_valid[ch] && !rdy;
      if (done && !drop) begin
        m_data[ch]  = W'(word);
        m_valid[ch] = 1;
      end else if (!done && m_valid[ch] && rdy) begin
        m_valid[ch] = 0;
      end
      if (drop) m_ovf[ch] = 1;
      else if (ovf_clr) m_ovf[ch] = 0;
    end
  endtask

  task automatic compare_all();
    check("a_valid", a_valid, m_valid[0]);
    check("a_data",  a_data,  m_data[0]);
    check("a_ovf",   a_ovf,   m_ovf[0]);
    check("b_valid", b_valid, m_valid[1]);
    check("b_data",  b_data,  m_data[1]);
    check("b_ovf",   b_ovf,   m_ovf[1]);
  endtask

  // Driver: apply one cycle of inputs, clock, then compare after the edge.
  task automatic step(input logic i_din, input logic i_dv, input logic i_sel,
                      input logic i_sync, input logic i_ar, input logic i_br,
                      input logic i_clr);
    din = i_din; din_valid = i_dv; sel = i_sel; sync = i_sync;
    a_ready = i_ar; b_ready = i_br; ovf_clr = i_clr;
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic send_word(input logic ch, input logic [W-1:0] w,
                           input logic ar, input logic br);
    for (int i = W - 1; i >= 0; i--) step(w[i], 1'b1, ch, 1'b0, ar, br, 1'b0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_a_data"},  a_data,  0);
    check({tag, "_a_valid"}, a_valid, 0);
    check({tag, "_a_ovf"},   a_ovf,   0);
    check({tag, "_b_data"},  b_data,  0);
    check({tag, "_b_valid"}, b_valid, 0);
    check({tag, "_b_ovf"},   b_ovf,   0);
  endtask

  initial begin
    logic [W-1:0] w_a5, w_f0, w_0f, w_33;
    w_a5 = 8'hA5; w_f0 = 8'hF0; w_0f = 8'h0F; w_33 = 8'h33;

    // Vectors: 8 bits of 0xA5 on A, then one idle cycle consuming the word.
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{din: w_a5[7-i], dv: 1'b1, sel: 1'b0, sync: 1'b0, ar: 1'b1,
                  br: 1'b1, clr: 1'b0, exp_a_valid: (i == 7),
                  exp_a_data: (i == 7) ? 8'hA5 : 8'h00, exp_b_valid: 1'b0};
    end
    vecs[8] = '{din: 1'b0, dv: 1'b0, sel: 1'b0, sync: 1'b0, ar: 1'b1, br: 1'b1,
                clr: 1'b0, exp_a_valid: 1'b0, exp_a_data: 8'hA5, exp_b_valid: 1'b0};

    // Reset.
    rst = 1'b1; din = 0; din_valid = 0; sel = 0; sync = 0;
    a_ready = 0; b_ready = 0; ovf_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;

    // 1: table-driven single A word.
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].din, vecs[i].dv, vecs[i].sel, vecs[i].sync,
           vecs[i].ar, vecs[i].br, vecs[i].clr);
      check($sformatf("t1_a_valid[%0d]", i), a_valid, vecs[i].exp_a_valid);
      check($sformatf("t1_a_data[%0d]", i),  a_data,  vecs[i].exp_a_data);
      check($sformatf("t1_b_valid[%0d]", i), b_valid, vecs[i].exp_b_valid);
    end

    // 2: interleaved channels.
    for (int i = W - 1; i >= 0; i--) begin
      step(w_f0[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(w_0f[i], 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("t2_a_data", a_data, 8'hF0);
    check("t2_b_data", b_data, 8'h0F);
    check("t2_a_valid", a_valid, 1);
    check("t2_b_valid", b_valid, 1);
    step(0, 0, 0, 0, 1, 1, 0);

    // 3: overflow with A stalled, then clear.
    send_word(1'b0, 8'h11, 1'b0, 1'b0);
    check("t3_first_valid", a_valid, 1);
    send_word(1'b0, 8'h22, 1'b0, 1'b0);
    check("t3_data_kept", a_data, 8'h11);
    check("t3_ovf_set", a_ovf, 1);
    check("t3_b_ovf", b_ovf, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    check("t3_ovf_clr", a_ovf, 0);
    check("t3_still_valid", a_valid, 1);

    // 4: handshake on the completion edge of 0x33.
    for (int i = W - 1; i >= 0; i--) step(w_33[i], 1'b1, 1'b0, 1'b0, (i == 0), 1'b0, 1'b0);
    check("t4_valid", a_valid, 1);
    check("t4_data", a_data, 8'h33);
    check("t4_no_ovf", a_ovf, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    check("t4_drained", a_valid, 0);

    // 5: sync mid-word with a bit on the same edge.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t5_partial", a_valid, 0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t5_before_last", a_valid, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t5_valid", a_valid, 1);
    check("t5_data", a_data, 8'h80);
    step(0, 0, 0, 0, 1, 0, 0);

    // 6: asynchronous reset mid-word with B holding a word.
    send_word(1'b1, 8'h5A, 1'b0, 1'b0);
    check("t6_b_valid", b_valid, 1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_zero_outputs("t6_async");
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t6_no_early_valid", b_valid, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t6_fresh_valid", b_valid, 1);
    check("t6_fresh_data", b_data, 8'hFE);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 30) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux2.md
Name: tdm_demux2

Overview:
- Two-channel serial time-division demultiplexer; the inverse of the team's 2:1 select mux, where `z = sel ? b : a`.
- It receives one serial bit stream whose per-bit channel is given by `sel`, and steers each bit to channel A (`sel=0`) or channel B (`sel=1`).
- Each channel deserialises its bits MSB-first into WIDTH-bit words and presents each word on a valid/ready output port.
- It sits downstream of the serial mux link and feeds per-channel consumers.

Parameters:
- WIDTH, 8, bits per output word (legal range 2..32).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  serial data bit.
- din_valid  input  1  `din`/`sel` qualify this cycle; the bit is consumed on the edge.
- sel  input  1  channel of the current bit: 0 = A, 1 = B.
- sync  input  1  frame sync; discards partial words in both channels.
- a_data  output  WIDTH  channel A word.
- a_valid  output  1  `a_data` holds an unconsumed word.
- a_ready  input  1  consumer A accepts the word when `a_valid & a_ready`.
- b_data  output  WIDTH  channel B word.
- b_valid  output  1  `b_data` holds an unconsumed word.
- b_ready  input  1  consumer B accepts the word when `b_valid & b_ready`.
- a_ovf  output  1  sticky: a channel A word was dropped.
- b_ovf  output  1  sticky: a channel B word was dropped.
- ovf_clr  input  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (asynchronous, takes effect immediately, `rst` high):
  - all outputs 0: `a_data`, `b_data`, `a_valid`, `b_valid`, `a_ovf`, `b_ovf`;
  - both shift registers and bit counters cleared.
- Reset mid-word discards all partial and held words. There is no recovery of data.
- Per-channel state (channel X in {A, B}):
  - shift register `sh_X[WIDTH-1:0]`;
  - bit counter `cnt_X` (0..WIDTH-1);
  - output register `X_data`/`X_valid`.
- FSM per channel, two states:
  - COLLECT: `X_valid = 0`.
  - HOLD: `X_valid = 1`.
  - COLLECT -> HOLD when a word completes.
  - HOLD -> COLLECT when `X_valid & X_ready` and no new word completes in the same cycle.
  - HOLD -> HOLD when a new word completes on the same edge as the handshake: the new word replaces the old one and `X_valid` stays 1.
- Bit acceptance: when `din_valid = 1`, only the channel selected by `sel` shifts:
  - `sh_X <= {sh_X[WIDTH-2:0], din}`;
  - `cnt_X` increments;
  - the other channel is untouched.
- Word completion happens when a bit is accepted with `cnt_X == WIDTH-1`:
  - the complete word `{sh_X[WIDTH-2:0], din}` is written to `X_data` on the same edge;
  - `cnt_X` wraps to 0;
  - `X_valid` is 1 from the next cycle, giving latency of 1 edge from the last bit to valid.
- Overflow: a word completes while `X_valid = 1` and `X_ready = 0`:
  - the new word is dropped;
  - `X_data` is retained;
  - `X_ovf` is set on that edge;
  - the counter still wraps to 0.
- `X_ovf` stays set until `ovf_clr` or `rst`. If the set and `ovf_clr` happen on the same edge, set wins.
- `sync = 1`:
  - both `cnt_A` and `cnt_B` clear to 0 and both shift registers clear;
  - `X_data`/`X_valid` are unaffected, so held words survive.
  - If `din_valid = 1` on the same edge, that bit is loaded as bit 1 of the new word: `cnt = 1`, `sh = din`.
- `X_data` must remain stable while `X_valid = 1` until the handshake.
- No combinational path from any input to any output.

Test Plan:
1. Reset, then stream `sel=0` bits 1,0,1,0,0,1,0,1 with `a_ready=1` -> `a_valid` high exactly 1 cycle after the 8th bit, `a_data = 0xA5`, `b_valid` stays 0.
2. Interleave `sel` 0/1 every bit: A gets 0xF0 bits, B gets 0x0F bits -> after the 16th `din_valid` cycle, `a_data = 0xF0` and `b_data = 0x0F`, both valid.
3. Hold `a_ready = 0` and send two A words, 0x11 then 0x22 -> `a_data` stays 0x11, `a_ovf = 1` one edge after the 0x22 completes. Pulse `ovf_clr` -> `a_ovf = 0`.
4. `a_ready` pulsed on the same edge as the completion of the next word 0x33 -> no overflow, `a_valid` stays 1, `a_data = 0x33`.
5. Send 5 bits to A, pulse `sync` with `din_valid=1, din=1, sel=0`, then 7 more bits 0,0,0,0,0,0,0 -> `a_data = 0x80` and the partial word is discarded.
6. Assert `rst` asynchronously mid-word while `b_valid = 1` -> all outputs 0 immediately without a clock edge. After release, a fresh 8-bit word is needed for a valid.
